rs_entry_scheduler: RTL and testbench
=====================================

# rs_entry_scheduler

Entry-level controller for one reservation station: tracks which of ENT_NUM entries are busy and grants up to two allocations per cycle to dispatch. Slot 0 receives the lowest free entry and slot 1 the highest. It also selects one ready entry per cycle for issue through a registered valid/ready stage. It sits between the dispatch stage and the RS storage array, and drives the RS write pointers and the issue read pointer. Lowest-index-first and highest-index-first priority search is used throughout.

## Interface
Parameters:
- ENT_NUM, 8, number of RS entries (≥2)
- ENT_SEL, 3, pointer width, equal to clog2(ENT_NUM)

Ports:
- clk  in  1  clock; all state updates on rising edge
- rst  in  1  asynchronous, active-high reset
- i_flush  in  1  kill all entries and the issue stage
- i_alloc_req  in  2  allocation request; bit0 is slot 0, bit1 is slot 1
- o_alloc_ack  out  1  all requested slots granted this cycle (all-or-nothing)
- o_alloc_ptr0  out  ENT_SEL  entry for slot 0, the lowest-index free entry
- o_alloc_ptr1  out  ENT_SEL  entry for slot 1, the highest-index free entry
- i_ready  in  ENT_NUM  per-entry operands-ready flags from the RS array
- o_issue_vld  out  1  registered issue valid
- o_issue_ptr  out  ENT_SEL  registered issue entry index
- i_issue_rdy  in  1  functional unit accepts o_issue_ptr
- o_busy  out  ENT_NUM  registered busy bitmap
- o_free_cnt  out  ENT_SEL+1  population count of ~o_busy

## Operation
- State consists of: busy[ENT_NUM-1:0], issue_vld, and issue_ptr.
- free = ~busy.
- o_alloc_ptr0 is the lowest set bit of free. o_alloc_ptr1 is the highest set bit of free. When free is 0, both pointers are 0.
- The required free count is popcount(i_alloc_req).
- o_alloc_ack = !i_flush && (o_free_cnt ≥ the required free count).
  - With i_alloc_req = 0, o_alloc_ack = 1.
  - A two-slot request needs ≥2 free entries, which guarantees ptr0 ≠ ptr1.
  - A slot-1-only request takes ptr1.
- When o_alloc_ack is set, the busy bits of the granted slots are set at the next edge. With no ack, busy is unchanged and dispatch stalls.
- Issue handshake: fire = issue_vld && i_issue_rdy.
- On fire, busy[issue_ptr] is cleared at the next edge.
- The issue stage loads when it is empty or firing (load_en = !issue_vld || i_issue_rdy).
- Candidate set = busy & i_ready & ~hold.
  - hold is the one-hot of issue_ptr when issue_vld is set; otherwise hold = 0.
  - The currently held entry is therefore never re-selected.
- Pick = lowest-index candidate.
  - If load_en, issue_vld gets (candidate set ≠ 0) and issue_ptr gets the pick, or 0 if there is no pick.
  - Otherwise issue_vld and issue_ptr hold their values.
- i_ready bits for non-busy entries are ignored.
- Simultaneous events:
  - Allocation and free of different entries in the same cycle both take effect.
  - An entry freed in cycle t is not visible to allocation until t+1.
  - Newly allocated entries are not issue candidates until the cycle after their busy bit sets.
- Flush: at the next edge, busy = 0 and issue_vld = 0, regardless of alloc/fire. o_alloc_ack is 0 during the flush cycle.
- Reset values:
  - busy = 0, so o_free_cnt = ENT_NUM.
  - o_issue_vld = 0 and o_issue_ptr = 0.
  - o_alloc_ptr0 = 0 and o_alloc_ptr1 = ENT_NUM-1.
- Reset asserted mid-operation clears all state immediately, without waiting for a clock edge.

## Timing
- Allocation ack and pointers are combinational from the registered busy bitmap. Busy updates 1 cycle after the grant.
- Issue latency: an entry that is busy and has i_ready high in cycle t appears on o_issue_vld/o_issue_ptr in cycle t+1.
- o_issue_vld/o_issue_ptr must remain stable while o_issue_vld=1 and i_issue_rdy=0.
- Sustained throughput: 1 issue per cycle while i_issue_rdy=1 and candidates exist. 2 allocations per cycle while ≥2 entries are free.
- o_free_cnt and o_busy are valid from the registered state with no extra latency.

## Test plan
- After reset, i_alloc_req=2'b11 -> o_alloc_ack=1, ptr0=0, ptr1=7. Next cycle o_busy=8'h81 and o_free_cnt=6.
- Fill to 7 busy (only entry 3 free), i_alloc_req=2'b11 -> o_alloc_ack=0 and busy unchanged. i_alloc_req=2'b01 -> ack=1 and ptr0=3.
- Busy=8'hFF, i_ready=8'h24, i_issue_rdy=1 -> o_issue_ptr=2, then 5 on the following cycle. Busy becomes 8'hDB.
- Entry 2 held with i_issue_rdy=0 for 3 cycles and i_ready=8'h24 -> ptr stays 2. When rdy rises, the next issue is 5, never a duplicate 2.
- Same cycle: fire on entry 4 and allocation request 2'b01 with entry 4 the only free-after-fire entry -> no ack that cycle. The next cycle grants ptr0=4.
- Mid-stream i_flush with issue_vld=1 -> the next cycle has o_busy=0, o_issue_vld=0, and o_free_cnt=8. o_alloc_ack=0 during the flush cycle. Asynchronous rst pulsed between edges clears outputs immediately.

Source files
------------

// File: rtl/rs_entry_scheduler.sv
// rs_entry_scheduler
// Entry-level controller for one reservation station. It tracks which entries
// are busy and grants up to two allocations per cycle to dispatch: slot 0 gets
// the lowest free entry and slot 1 gets the highest. It also picks one ready
// entry per cycle and presents it through a registered valid/ready issue stage.
//
// Ports:
//   clk           clock, all state updates on rising edge
//   rst           asynchronous active-high reset
//   i_flush       kill all entries and the issue stage at the next edge
//   i_alloc_req   allocation request, bit0 = slot 0, bit1 = slot 1
//   o_alloc_ack   every requested slot granted this cycle (all-or-nothing)
//   o_alloc_ptr0  slot 0 entry (lowest free)
//   o_alloc_ptr1  slot 1 entry (highest free)
//   i_ready       per-entry operands-ready flags
//   o_issue_vld   registered issue valid
//   o_issue_ptr   registered issue entry index
//   i_issue_rdy   functional unit accepts o_issue_ptr
//   o_busy        registered busy bitmap
//   o_free_cnt    number of free entries
module rs_entry_scheduler #(
    parameter int ENT_NUM = 8,
    parameter int ENT_SEL = 3
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               i_flush,
    input  logic [1:0]         i_alloc_req,
    output logic               o_alloc_ack,
    output logic [ENT_SEL-1:0] o_alloc_ptr0,
    output logic [ENT_SEL-1:0] o_alloc_ptr1,
    input  logic [ENT_NUM-1:0] i_ready,
    output logic               o_issue_vld,
    output logic [ENT_SEL-1:0] o_issue_ptr,
    input  logic               i_issue_rdy,
    output logic [ENT_NUM-1:0] o_busy,
    output logic [ENT_SEL:0]   o_free_cnt
);

    logic [ENT_NUM-1:0] busy;
    logic               issue_vld;
    logic [ENT_SEL-1:0] issue_ptr;

    logic [ENT_NUM-1:0] free;
    logic [ENT_SEL-1:0] ptr0;
    logic [ENT_SEL-1:0] ptr1;
    logic [ENT_SEL:0]   free_cnt;
    logic [ENT_SEL:0]   req_cnt;
    logic               alloc_ack;

    logic               fire;
    logic               load_en;
    logic [ENT_NUM-1:0] hold;
    logic [ENT_NUM-1:0] cand;
    logic [ENT_SEL-1:0] pick;
    logic [ENT_NUM-1:0] busy_set;
    logic [ENT_NUM-1:0] busy_clr;

    assign free = ~busy;

    // Free-entry search: descending loop leaves the lowest hit in ptr0,
    // ascending loop leaves the highest hit in ptr1. Both stay 0 when full.
    always_comb begin
        ptr0     = '0;
        ptr1     = '0;
        free_cnt = '0;
        for (int i = ENT_NUM - 1; i >= 0; i--) begin
            if (free[i]) ptr0 = ENT_SEL'(i);
        end
        for (int i = 0; i < ENT_NUM; i++) begin
            if (free[i]) ptr1 = ENT_SEL'(i);
            free_cnt = free_cnt + (ENT_SEL+1)'(free[i]);
        end
    end

    assign req_cnt   = (ENT_SEL+1)'(i_alloc_req[0]) + (ENT_SEL+1)'(i_alloc_req[1]);
    // Requiring two free entries for a dual request guarantees ptr0 != ptr1.
    assign alloc_ack = !i_flush && (free_cnt >= req_cnt);

    assign fire    = issue_vld && i_issue_rdy;
    assign load_en = !issue_vld || i_issue_rdy;

    // The held entry is masked so a stalled or firing entry is never picked twice.
    always_comb begin
        hold = '0;
        if (issue_vld) hold[issue_ptr] = 1'b1;
    end

    assign cand = busy & i_ready & ~hold;

    always_comb begin
        pick = '0;
        for (int i = ENT_NUM - 1; i >= 0; i--) begin
            if (cand[i]) pick = ENT_SEL'(i);
        end
    end

    // Allocation only touches free entries and fire only touches a busy one,
    // so the set and clear masks never overlap.
    always_comb begin
        busy_set = '0;
        if (alloc_ack) begin
            if (i_alloc_req[0]) busy_set[ptr0] = 1'b1;
            if (i_alloc_req[1]) busy_set[ptr1] = 1'b1;
        end
    end

    always_comb begin
        busy_clr = '0;
        if (fire) busy_clr[issue_ptr] = 1'b1;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            busy      <= '0;
            issue_vld <= 1'b0;
            issue_ptr <= '0;
        end else if (i_flush) begin
            busy      <= '0;
            issue_vld <= 1'b0;
            issue_ptr <= '0;
        end else begin
            busy <= (busy & ~busy_clr) | busy_set;
            if (load_en) begin
                issue_vld <= |cand;
                issue_ptr <= pick;
            end
        end
    end

    assign o_alloc_ack  = alloc_ack;
    assign o_alloc_ptr0 = ptr0;
    assign o_alloc_ptr1 = ptr1;
    assign o_issue_vld  = issue_vld;
    assign o_issue_ptr  = issue_ptr;
    assign o_busy       = busy;
    assign o_free_cnt   = free_cnt;

endmodule

// File: tb/tb_rs_entry_scheduler.sv
module tb_rs_entry_scheduler;

    localparam int N = 8;
    localparam int S = 3;

    logic         clk = 1'b0;
    logic         rst;
    logic         i_flush;
    logic [1:0]   i_alloc_req;
    logic         o_alloc_ack;
    logic [S-1:0] o_alloc_ptr0;
    logic [S-1:0] o_alloc_ptr1;
    logic [N-1:0] i_ready;
    logic         o_issue_vld;
    logic [S-1:0] o_issue_ptr;
    logic         i_issue_rdy;
    logic [N-1:0] o_busy;
    logic [S:0]   o_free_cnt;

    rs_entry_scheduler #(.ENT_NUM(N), .ENT_SEL(S)) dut (
        .clk          (clk),
        .rst          (rst),
        .i_flush      (i_flush),
        .i_alloc_req  (i_alloc_req),
        .o_alloc_ack  (o_alloc_ack),
        .o_alloc_ptr0 (o_alloc_ptr0),
        .o_alloc_ptr1 (o_alloc_ptr1),
        .i_ready      (i_ready),
        .o_issue_vld  (o_issue_vld),
        .o_issue_ptr  (o_issue_ptr),
        .i_issue_rdy  (i_issue_rdy),
        .o_busy       (o_busy),
        .o_free_cnt   (o_free_cnt)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_mis = 0;

    task automatic chk(input string name, input int act, input int exp);
        n_cmp++;
        if (act !== exp) begin
            n_mis++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    typedef struct {
        logic [1:0]   req;
        logic [N-1:0] ready;
        logic         rdy;
        logic         flush;
        logic         ack;
        logic [S-1:0] p0;
        logic [S-1:0] p1;
        logic [N-1:0] busy;
        logic [S:0]   cnt;
        logic         vld;
        logic [S-1:0] iptr;
    } vec_t;

    vec_t tbl[25];

    // Behavioural reference: busy kept as an array of flags, priority searches
    // done by scanning, issue stage as a (valid, index) pair.
    bit m_busy[N];
    bit m_vld;
    int m_ptr;

    function automatic int m_busy_vec();
        int v = 0;
        for (int i = 0; i < N; i++) if (m_busy[i]) v += (1 << i);
        return v;
    endfunction

    task automatic model_reset();
        for (int i = 0; i < N; i++) m_busy[i] = 0;
        m_vld = 0;
        m_ptr = 0;
    endtask

    // Compare DUT against the model for the current inputs, then advance the model.
    task automatic model_check_and_step();
        int nfree = 0;
        int lo = -1;
        int hi = -1;
        int need;
        bit ack;
        bit nb[N];
        int sel = -1;
        for (int i = 0; i < N; i++) begin
            if (!m_busy[i]) begin
                nfree++;
                if (lo < 0) lo = i;
                hi = i;
            end
        end
        need = int'(i_alloc_req[0]) + int'(i_alloc_req[1]);
        ack  = !i_flush && (nfree >= need);
        chk("rnd_ack",  int'(o_alloc_ack), int'(ack));
        chk("rnd_ptr0", int'(o_alloc_ptr0), (lo < 0) ? 0 : lo);
        chk("rnd_ptr1", int'(o_alloc_ptr1), (hi < 0) ? 0 : hi);
        chk("rnd_cnt",  int'(o_free_cnt), nfree);
        chk("rnd_busy", int'(o_busy), m_busy_vec());
        chk("rnd_vld",  int'(o_issue_vld), int'(m_vld));
        if (m_vld) chk("rnd_iptr", int'(o_issue_ptr), m_ptr);

        for (int i = 0; i < N; i++) nb[i] = m_busy[i];
        if (i_flush) begin
            for (int i = 0; i < N; i++) nb[i] = 0;
            m_vld = 0;
            m_ptr = 0;
        end else begin
            if (m_vld && i_issue_rdy) nb[m_ptr] = 0;
            if (ack && i_alloc_req[0]) nb[lo] = 1;
            if (ack && i_alloc_req[1]) nb[hi] = 1;
            if (!m_vld || i_issue_rdy) begin
                for (int i = 0; i < N; i++) begin
                    if (sel < 0 && m_busy[i] && i_ready[i] && !(m_vld && i == m_ptr)) sel = i;
                end
                m_vld = (sel >= 0);
                m_ptr = (sel >= 0) ? sel : 0;
            end
        end
        for (int i = 0; i < N; i++) m_busy[i] = nb[i];
    endtask

    initial begin
        //            req    ready  rdy   fl    ack   p0    p1    busy   cnt   vld   iptr
        tbl[0]  = '{2'd3, 8'h00, 1'b0, 1'b0, 1'b1, 3'd0, 3'd7, 8'h00, 4'd8, 1'b0, 3'd0};
        tbl[1]  = '{2'd3, 8'h00, 1'b0, 1'b0, 1'b1, 3'd1, 3'd6, 8'h81, 4'd6, 1'b0, 3'd0};
        tbl[2]  = '{2'd3, 8'h00, 1'b0, 1'b0, 1'b1, 3'd2, 3'd5, 8'hC3, 4'd4, 1'b0, 3'd0};
        tbl[3]  = '{2'd2, 8'h00, 1'b0, 1'b0, 1'b1, 3'd3, 3'd4, 8'hE7, 4'd2, 1'b0, 3'd0};
        tbl[4]  = '{2'd3, 8'h00, 1'b0, 1'b0, 1'b0, 3'd3, 3'd3, 8'hF7, 4'd1, 1'b0, 3'd0};
        tbl[5]  = '{2'd1, 8'h00, 1'b0, 1'b0, 1'b1, 3'd3, 3'd3, 8'hF7, 4'd1, 1'b0, 3'd0};
        tbl[6]  = '{2'd0, 8'h24, 1'b1, 1'b0, 1'b1, 3'd0, 3'd0, 8'hFF, 4'd0, 1'b0, 3'd0};
        tbl[7]  = '{2'd0, 8'h24, 1'b1, 1'b0, 1'b1, 3'd0, 3'd0, 8'hFF, 4'd0, 1'b1, 3'd2};
        tbl[8]  = '{2'd0, 8'h24, 1'b1, 1'b0, 1'b1, 3'd2, 3'd2, 8'hFB, 4'd1, 1'b1, 3'd5};
        tbl[9]  = '{2'd0, 8'h00, 1'b0, 1'b0, 1'b1, 3'd2, 3'd5, 8'hDB, 4'd2, 1'b0, 3'd0};
        tbl[10] = '{2'd3, 8'h00, 1'b0, 1'b0, 1'b1, 3'd2, 3'd5, 8'hDB, 4'd2, 1'b0, 3'd0};
        tbl[11] = '{2'd0, 8'h24, 1'b0, 1'b0, 1'b1, 3'd0, 3'd0, 8'hFF, 4'd0, 1'b0, 3'd0};
        tbl[12] = '{2'd0, 8'h24, 1'b0, 1'b0, 1'b1, 3'd0, 3'd0, 8'hFF, 4'd0, 1'b1, 3'd2};
        tbl[13] = '{2'd0, 8'h24, 1'b0, 1'b0, 1'b1, 3'd0, 3'd0, 8'hFF, 4'd0, 1'b1, 3'd2};
        tbl[14] = '{2'd0, 8'h24, 1'b0, 1'b0, 1'b1, 3'd0, 3'd0, 8'hFF, 4'd0, 1'b1, 3'd2};
        tbl[15] = '{2'd0, 8'h24, 1'b1, 1'b0, 1'b1, 3'd0, 3'd0, 8'hFF, 4'd0, 1'b1, 3'd2};
        tbl[16] = '{2'd0, 8'h24, 1'b0, 1'b0, 1'b1, 3'd2, 3'd2, 8'hFB, 4'd1, 1'b1, 3'd5};
        tbl[17] = '{2'd1, 8'h00, 1'b1, 1'b0, 1'b1, 3'd2, 3'd2, 8'hFB, 4'd1, 1'b1, 3'd5};
        tbl[18] = '{2'd1, 8'h10, 1'b0, 1'b0, 1'b1, 3'd5, 3'd5, 8'hDF, 4'd1, 1'b0, 3'd0};
        tbl[19] = '{2'd1, 8'h00, 1'b1, 1'b0, 1'b0, 3'd0, 3'd0, 8'hFF, 4'd0, 1'b1, 3'd4};
        tbl[20] = '{2'd1, 8'h00, 1'b0, 1'b0, 1'b1, 3'd4, 3'd4, 8'hEF, 4'd1, 1'b0, 3'd0};
        tbl[21] = '{2'd0, 8'h81, 1'b0, 1'b0, 1'b1, 3'd0, 3'd0, 8'hFF, 4'd0, 1'b0, 3'd0};
        tbl[22] = '{2'd0, 8'h81, 1'b1, 1'b0, 1'b1, 3'd0, 3'd0, 8'hFF, 4'd0, 1'b1, 3'd0};
        tbl[23] = '{2'd1, 8'h00, 1'b0, 1'b1, 1'b0, 3'd0, 3'd0, 8'hFE, 4'd1, 1'b1, 3'd7};
        tbl[24] = '{2'd0, 8'hFF, 1'b0, 1'b0, 1'b1, 3'd0, 3'd7, 8'h00, 4'd8, 1'b0, 3'd0};

        rst = 1'b1;
        i_flush = 1'b0;
        i_alloc_req = 2'd0;
        i_ready = '0;
        i_issue_rdy = 1'b0;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;

        // Directed table: inputs driven just after an edge, outputs sampled on
        // the falling edge of the same cycle.
        for (int r = 0; r < 25; r++) begin
            i_alloc_req = tbl[r].req;
            i_ready     = tbl[r].ready;
            i_issue_rdy = tbl[r].rdy;
            i_flush     = tbl[r].flush;
            @(negedge clk);
            chk($sformatf("tbl%0d_ack", r),  int'(o_alloc_ack),  int'(tbl[r].ack));
            chk($sformatf("tbl%0d_ptr0", r), int'(o_alloc_ptr0), int'(tbl[r].p0));
            chk($sformatf("tbl%0d_ptr1", r), int'(o_alloc_ptr1), int'(tbl[r].p1));
            chk($sformatf("tbl%0d_busy", r), int'(o_busy),       int'(tbl[r].busy));
            chk($sformatf("tbl%0d_cnt", r),  int'(o_free_cnt),   int'(tbl[r].cnt));
            chk($sformatf("tbl%0d_vld", r),  int'(o_issue_vld),  int'(tbl[r].vld));
            chk($sformatf("tbl%0d_iptr", r), int'(o_issue_ptr),  int'(tbl[r].iptr));
            @(posedge clk);
            #1;
        end

        // Asynchronous reset between edges with live state.
        i_alloc_req = 2'd3;
        i_ready     = 8'hFF;
        i_issue_rdy = 1'b0;
        i_flush     = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        i_alloc_req = 2'd0;
        chk("pre_rst_busy", int'(o_busy), 8'hC3);
        chk("pre_rst_vld",  int'(o_issue_vld), 1);
        #2 rst = 1'b1;
        #1;
        chk("arst_busy", int'(o_busy), 0);
        chk("arst_vld",  int'(o_issue_vld), 0);
        chk("arst_iptr", int'(o_issue_ptr), 0);
        chk("arst_cnt",  int'(o_free_cnt), 8);
        chk("arst_ptr0", int'(o_alloc_ptr0), 0);
        chk("arst_ptr1", int'(o_alloc_ptr1), 7);
        @(posedge clk);
        #1 rst = 1'b0;

        // Randomized run against the reference model.
        model_reset();
        for (int c = 0; c < 3000; c++) begin
            i_alloc_req = 2'($urandom_range(0, 3));
            i_ready     = N'($urandom);
            i_issue_rdy = ($urandom_range(0, 3) != 0);
            i_flush     = ($urandom_range(0, 60) == 0);
            @(negedge clk);
            model_check_and_step();
            @(posedge clk);
            #1;
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
        $finish;
    end

endmodule
